apb_slave_mem: RTL
==================

// Module: apb_slave_mem
// PURPOSE
//  APB completer: word-addressed register/memory bank answering transfers from
//  the APB master on the same PSEL/PENABLE/PWRITE/PADDR/PWDATA bus. Inserts a
//  programmable number of wait states and flags bad accesses with PSLVERR.
//  Primary bench target and default peripheral for the APB master.
// PARAMETERS
//  DATA_WIDTH   32   width of PWDATA/PRDATA and of each memory word
//  ADDR_WIDTH   32   width of PADDR
//  DEPTH        16   number of words; any positive integer
//  BASE_ADDR    0    byte address of word 0
//  WAIT_CYCLES  1    wait states before PREADY; 0..15
// PORTS
//  PCLK     in   1           clock; all state on rising edge
//  PRESETn  in   1           reset; synchronous, active-high (1 = reset)
//  PSEL     in   1           slave select
//  PENABLE  in   1           access-phase strobe
//  PWRITE   in   1           1 = write, 0 = read
//  PADDR    in   ADDR_WIDTH  byte address
//  PWDATA   in   DATA_WIDTH  write data
//  PRDATA   out  DATA_WIDTH  read data; valid while PREADY=1
//  PREADY   out  1           transfer completes on edge where PSEL&PENABLE&PREADY
//  PSLVERR  out  1           error response; valid only while PREADY=1
// BEHAVIOUR
//  Reset (PRESETn=1 at an edge): state IDLE, PRDATA=0, PREADY=0, PSLVERR=0,
//   wait counter=0, every memory word=0. Overrides any transfer in progress.
//  Decode: off=PADDR-BASE_ADDR; idx=off>>2; ERR if PADDR<BASE_ADDR,
//   PADDR[1:0]!=0, or idx>=DEPTH.
//  All outputs registered. FSM states IDLE, WAIT, RESP:
//   IDLE: PREADY=0, PSLVERR=0. On edge with PSEL=1 & PENABLE=0 (setup):
//    latch PADDR, PWRITE, PWDATA, ERR; cnt<=WAIT_CYCLES.
//    If WAIT_CYCLES=0, go RESP this edge: PREADY high in the first access cycle.
//    Otherwise go WAIT. PSEL=1 & PENABLE=1 seen in IDLE (no setup): ignored.
//   WAIT: cnt decrements each edge. When cnt reaches 1, go RESP. Result: PREADY
//    is high in access cycle WAIT_CYCLES+1. If PSEL=0 at any edge: abort, go
//    IDLE, no write.
//   RESP: PREADY=1. PSLVERR=latched ERR. Read with !ERR: PRDATA=mem[idx].
//    Read with ERR: PRDATA=0. PRDATA is loaded on the same edge PREADY rises.
//    On edge with PSEL&PENABLE (completion):
//     - write with !ERR commits mem[idx]<=latched PWDATA;
//     - write with ERR leaves memory unchanged;
//     - PREADY, PSLVERR and PRDATA return to 0;
//     - state goes IDLE.
//    If PSEL=0 in RESP: drop to IDLE, no write.
//  Back-to-back: a setup on the cycle after completion is accepted normally.
//   There are no idle cycles required between transfers.
//  Latency, setup edge to completion edge: WAIT_CYCLES+2 edges
//   (2 with no waits, matching minimum APB).
//  PWDATA and PADDR are sampled only at setup; changes during access are ignored.
//  Simultaneous read/write to same word is impossible (one transfer in flight).
// TESTING
//  1 Reset: PRESETn=1 two edges -> PREADY=0, PSLVERR=0, PRDATA=0;
//    read of idx 0..15 returns 0.
//  2 WAIT_CYCLES=0: write 0xDEADBEEF @0x08, then read 0x08 -> PREADY high
//    first access cycle, PRDATA=0xDEADBEEF, PSLVERR=0.
//  3 WAIT_CYCLES=3: read 0x04 -> PREADY low 3 access cycles, high in 4th;
//    completion 5 edges after setup.
//  4 Errors: write 0x40 (idx 16) and 0x06 (misaligned) -> PSLVERR=1 with PREADY;
//    subsequent reads of 0x00 and 0x04 are unchanged; error read PRDATA=0.
//  5 Back-to-back: writes 0x0/0x4/0x8 with no idle cycles, then reads -> all
//    three values returned in order.
//  6 Abort/reset: PSEL dropped mid-WAIT, or PRESETn=1 in RESP of a write ->
//    target word not written; FSM IDLE; next transfer completes normally.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed memory bank.
// Programmable wait states; PSLVERR on out-of-range or misaligned access.
module apb_slave_mem #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int BASE_ADDR   = 0,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  err_q;

    logic                  ready_d;
    logic                  slverr_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic                  latch;
    logic                  commit;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   off_ext;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_err;
    logic [DATA_WIDTH-1:0] rd_live;
    logic [DATA_WIDTH-1:0] rd_held;

    // Borrow out of the subtraction flags addresses below the base.
    assign off_ext  = {1'b0, PADDR} - {1'b0, BASE};
    assign word_off = off_ext[ADDR_WIDTH-1:0] >> 2;
    assign dec_idx  = word_off[IDX_W-1:0];
    assign dec_err  = off_ext[ADDR_WIDTH]
                   || (PADDR[1:0] != 2'b00)
                   || (word_off >= LIMIT);
    assign rd_live  = mem[dec_idx];
    assign rd_held  = mem[idx_q];

    // Next state and next registered bus outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        slverr_d = 1'b0;
        rdata_d  = '0;
        latch    = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    latch = 1'b1;
                    cnt_d = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = dec_err;
                        if (!PWRITE && !dec_err) begin
                            rdata_d = rd_live;
                        end
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = err_q;
                        if (!wr_q && !err_q) begin
                            rdata_d = rd_held;
                        end
                    end
                end
            end
            RESP: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    commit  = wr_q && !err_q;
                    state_d = IDLE;
                end else begin
                    ready_d  = 1'b1;
                    slverr_d = err_q;
                    rdata_d  = PRDATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, transfer capture and registered outputs.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            PREADY  <= ready_d;
            PSLVERR <= slverr_d;
            PRDATA  <= rdata_d;
            if (latch) begin
                idx_q   <= dec_idx;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
                err_q   <= dec_err;
            end
        end
    end

    // Memory bank; writes commit only on a clean completion.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
